// File: rtl/sample_cal_pkg.sv
// Shared definitions for the sample_cal calibration stage: FSM states,
// coefficient defaults, config select codes and saturation bounds.
package sample_cal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIFF = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] GAIN_UNITY     = 16'h4000;
  localparam logic        CFG_SEL_OFFSET = 1'b0;
  localparam logic        CFG_SEL_GAIN   = 1'b1;

  // Largest value representable in a w-bit two's complement word.
  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 32'sd1));
  endfunction

endpackage

// File: rtl/sample_cal_sat_shift.sv
// sat_shift: combinational arithmetic right shift (floor toward -inf)
// followed by saturation to an OUT_W-bit signed range. The clip output
// flags that the result was clamped. Reusable for later gain stages.
module sat_shift
  import sample_cal_pkg::*;
#(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int SHIFT = 14
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(OUT_W));

  logic signed [IN_W-1:0] shifted_s;

  // Shift, then clamp into the output range and report clamping.
  always_comb begin
    shifted_s = din >>> SHIFT;
    if (shifted_s > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      clip = 1'b1;
    end else if (shifted_s < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      clip = 1'b1;
    end else begin
      dout = shifted_s[OUT_W-1:0];
      clip = 1'b0;
    end
  end

endmodule

// File: rtl/sample_cal.sv
// sample_cal: per-channel ADC calibration, out = sat((in - offset) * gain
// >>> GAIN_FRAC), one shared multiplier stepped across channels.
// Optional macro SAMPLE_CAL_CLIP_FLAG_EN adds sticky per-channel clip flags
// (clip output) with a clear input (clip_clr).
module sample_cal
  import sample_cal_pkg::*;
#(
  parameter int W         = 16,
  parameter int N_CH      = 4,
  parameter int GAIN_FRAC = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] in_sample,
  output logic              out_valid,
  output logic [N_CH*W-1:0] out_sample,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic              overrun
`ifdef SAMPLE_CAL_CLIP_FLAG_EN
  ,
  output logic [N_CH-1:0]   clip,
  input  logic              clip_clr
`endif
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t                 state_r, next_state_s;
  logic [CH_W-1:0]        ch_r;
  logic                   last_ch_s;
  logic signed [W-1:0]    in_lat_r   [N_CH];
  logic signed [W-1:0]    out_r      [N_CH];
  logic signed [15:0]     off_sh_r   [N_CH];
  logic signed [15:0]     gain_sh_r  [N_CH];
  logic signed [15:0]     off_act_r  [N_CH];
  logic signed [15:0]     gain_act_r [N_CH];
  logic signed [W:0]      d_r;
  logic signed [W+16:0]   prod_s;
  logic signed [W-1:0]    sat_s;
  logic                   sat_clip_s;
  logic                   in_ready_r, out_valid_r, overrun_r;

  assign last_ch_s = (ch_r == CH_W'(N_CH - 1));
  assign prod_s    = (W+17)'(d_r) * (W+17)'(gain_act_r[ch_r]);

  sat_shift #(
    .IN_W (W + 17),
    .OUT_W(W),
    .SHIFT(GAIN_FRAC)
  ) u_sat_shift (
    .din (prod_s),
    .dout(sat_s),
    .clip(sat_clip_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // FSM next-state logic: one DIFF/MUL pair per channel, then DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) next_state_s = DIFF;
        else          next_state_s = IDLE;
      end
      DIFF: next_state_s = MUL;
      MUL: begin
        if (last_ch_s) next_state_s = DONE;
        else           next_state_s = DIFF;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Shadow coefficient bank: config writes land here at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        off_sh_r[c]  <= 16'sh0000;
        gain_sh_r[c] <= GAIN_UNITY;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_we && (cfg_addr[2:1] == 2'(c))) begin
          if (cfg_addr[0] == CFG_SEL_GAIN) gain_sh_r[c] <= cfg_data;
          else                              off_sh_r[c]  <= cfg_data;
        end
      end
    end
  end

  // Datapath: latch frame and active coefficients on accept, then compute
  // the difference and the saturated product one channel at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_r <= {CH_W{1'b0}};
      d_r  <= {(W+1){1'b0}};
      for (int c = 0; c < N_CH; c++) begin
        in_lat_r[c]   <= {W{1'b0}};
        out_r[c]      <= {W{1'b0}};
        off_act_r[c]  <= 16'sh0000;
        gain_act_r[c] <= GAIN_UNITY;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            ch_r <= {CH_W{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
              in_lat_r[c]   <= in_sample[c*W +: W];
              off_act_r[c]  <= off_sh_r[c];
              gain_act_r[c] <= gain_sh_r[c];
            end
          end
        end
        DIFF: d_r <= (W+1)'(in_lat_r[ch_r]) - (W+1)'(off_act_r[ch_r]);
        MUL: begin
          out_r[ch_r] <= sat_s;
          if (!last_ch_s) ch_r <= ch_r + CH_W'(1);
        end
        default: ch_r <= ch_r;
      endcase
    end
  end

  // Registered handshake/status: ready in IDLE, valid pulse in DONE,
  // sticky overrun when a frame arrives outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      if (in_valid && (state_r != IDLE)) overrun_r <= 1'b1;
    end
  end

  // Pack the per-channel result registers onto the output bus.
  always_comb begin
    out_sample = {(N_CH*W){1'b0}};
    for (int c = 0; c < N_CH; c++) out_sample[c*W +: W] = out_r[c];
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

`ifdef SAMPLE_CAL_CLIP_FLAG_EN
  logic [N_CH-1:0] clip_r;

  // Sticky per-channel clip flags; a new saturation wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_r <= {N_CH{1'b0}};
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if ((state_r == MUL) && sat_clip_s && (ch_r == CH_W'(c))) clip_r[c] <= 1'b1;
        else if (clip_clr)                                         clip_r[c] <= 1'b0;
        else                                                       clip_r[c] <= clip_r[c];
      end
    end
  end

  assign clip = clip_r;
`else
  logic clip_unused_s;
  assign clip_unused_s = sat_clip_s;
`endif

endmodule
